sbox_share_ctrl: RTL and testbench

//  Serial AES SubBytes scheduler: shares ONE S-box (GF(2^8) inverse + S_affine) between
//  two requesters, the round datapath (128-bit state) and the key expansion (32-bit SubWord).

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/sbox_byte.sv | 19 +
 rtl/sbox_share_ctrl.sv | 134 +++++++++++++
 tb/tb_sbox_share_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word widths, scheduler FSM encoding and GF(2^8) helpers
// used by the combinational S-box.
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam int ST_W   = 128;
    localparam int KW_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_ST = 2'd1,
        RUN_KW = 2'd2,
        DONE   = 2'd3
    } ctrl_state_t;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0); addition chain 2,3,6,12,15,240,252,254.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a240 = gf_mul(a15, a15);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

endpackage

// File: rtl/sbox_byte.sv
// Combinational AES S-box for one byte: multiplicative inverse followed by the affine map.
module sbox_byte
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] i_byte,
    output logic [BYTE_W-1:0] o_byte
);

    logic [BYTE_W-1:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/sbox_share_ctrl.sv
// Serial SubBytes scheduler: one S-box shared between the round state and key-word SubWord,
// one byte per cycle. Handshake: a request transfers on the rising edge where valid && ready.
module sbox_share_ctrl
    import aes_pkg::*;
#(
    parameter int NB_ST       = 16,
    parameter int NB_KW       = 4,
    parameter int KW_PRIORITY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [NB_ST*BYTE_W-1:0] st_in,
    output logic                    st_done,
    output logic [NB_ST*BYTE_W-1:0] st_out,
    input  logic                    kw_valid,
    output logic                    kw_ready,
    input  logic [NB_KW*BYTE_W-1:0] kw_in,
    output logic                    kw_done,
    output logic [NB_KW*BYTE_W-1:0] kw_out,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W   = $clog2(NB_ST);
    localparam int ST_BITS = NB_ST * BYTE_W;
    localparam int KW_BITS = NB_KW * BYTE_W;

    ctrl_state_t         r_state;
    ctrl_state_t         w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sel_kw;
    logic [ST_BITS-1:0]  r_work;
    logic [ST_BITS-1:0]  r_st_out;
    logic [KW_BITS-1:0]  r_kw_out;
    logic [BYTE_W-1:0]   w_sbox_in;
    logic [BYTE_W-1:0]   w_sbox_out;
    logic                w_last;
    logic                w_acc_st;
    logic                w_acc_kw;

    assign w_sbox_in = r_work[{r_cnt, 3'b000} +: BYTE_W];

    sbox_byte u_sbox (
        .i_byte (w_sbox_in),
        .o_byte (w_sbox_out)
    );

    assign w_last = (r_state == RUN_ST) ? (r_cnt == CNT_W'(NB_ST - 1))
                                        : (r_cnt == CNT_W'(NB_KW - 1));

    assign w_acc_st  = st_valid && st_ready;
    assign w_acc_kw  = kw_valid && kw_ready;
    assign st_out    = r_st_out;
    assign kw_out    = r_kw_out;
    assign dbg_state = r_state;

    always_comb begin
        w_next   = r_state;
        st_ready = 1'b0;
        kw_ready = 1'b0;
        st_done  = 1'b0;
        kw_done  = 1'b0;
        busy     = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                // The losing side sees ready low and must keep its request up.
                if (KW_PRIORITY != 0) begin
                    kw_ready = 1'b1;
                    st_ready = !kw_valid;
                end else begin
                    st_ready = 1'b1;
                    kw_ready = !st_valid;
                end
                if (kw_valid && kw_ready) begin
                    w_next = RUN_KW;
                end else if (st_valid && st_ready) begin
                    w_next = RUN_ST;
                end
            end
            RUN_ST, RUN_KW: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                st_done = !r_sel_kw;
                kw_done = r_sel_kw;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sel_kw <= 1'b0;
            r_work   <= '0;
            r_st_out <= '0;
            r_kw_out <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_acc_kw) begin
                        r_work   <= {{(ST_BITS - KW_BITS){1'b0}}, kw_in};
                        r_sel_kw <= 1'b1;
                        r_cnt    <= '0;
                    end else if (w_acc_st) begin
                        r_work   <= st_in;
                        r_sel_kw <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RUN_ST: begin
                    for (int k = 0; k < NB_ST; k++) begin
                        if (r_cnt == CNT_W'(k)) r_st_out[k*BYTE_W +: BYTE_W] <= w_sbox_out;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                RUN_KW: begin
                    for (int k = 0; k < NB_KW; k++) begin
                        if (r_cnt == CNT_W'(k)) r_kw_out[k*BYTE_W +: BYTE_W] <= w_sbox_out;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                DONE: r_cnt <= '0;
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: instance 0 has key-word priority, instance 1 has state priority.
module tb_sbox_share_ctrl;

    localparam int NB_ST = 16;
    localparam int NB_KW = 4;

    // Reference AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct {
        logic         is_kw;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [1:0]            st_valid = '0;
    logic [1:0]            st_ready;
    logic [1:0][127:0]     st_in = '0;
    logic [1:0]            st_done;
    logic [1:0][127:0]     st_out;
    logic [1:0]            kw_valid = '0;
    logic [1:0]            kw_ready;
    logic [1:0][31:0]      kw_in = '0;
    logic [1:0]            kw_done;
    logic [1:0][31:0]      kw_out;
    logic [1:0]            busy;
    logic [1:0][1:0]       dbg_state;

    int                    cyc = 0;
    int                    n_checks = 0;
    int                    n_pass = 0;
    logic [127:0]          st_exp_q[$];
    int                    st_cyc_q[$];
    logic [31:0]           kw_exp_q[$];
    int                    kw_cyc_q[$];
    logic [1:0][127:0]     last_st = '0;
    logic [1:0][31:0]      last_kw = '0;
    vec_t                  vecs[8];

    sbox_share_ctrl #(.NB_ST(NB_ST), .NB_KW(NB_KW), .KW_PRIORITY(1)) u_dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid[0]), .st_ready(st_ready[0]), .st_in(st_in[0]),
        .st_done(st_done[0]), .st_out(st_out[0]),
        .kw_valid(kw_valid[0]), .kw_ready(kw_ready[0]), .kw_in(kw_in[0]),
        .kw_done(kw_done[0]), .kw_out(kw_out[0]),
        .busy(busy[0]), .dbg_state(dbg_state[0])
    );

    sbox_share_ctrl #(.NB_ST(NB_ST), .NB_KW(NB_KW), .KW_PRIORITY(0)) u_dut_p0 (
        .clk(clk), .rst(rst),
        .st_valid(st_valid[1]), .st_ready(st_ready[1]), .st_in(st_in[1]),
        .st_done(st_done[1]), .st_out(st_out[1]),
        .kw_valid(kw_valid[1]), .kw_ready(kw_ready[1]), .kw_in(kw_in[1]),
        .kw_done(kw_done[1]), .kw_out(kw_out[1]),
        .busy(busy[1]), .dbg_state(dbg_state[1])
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] ref_sbox(input logic [7:0] b);
        int idx;
        idx = int'(b);
        return SBOX_TAB[2047 - 8*idx -: 8];
    endfunction

    function automatic logic [127:0] model_st(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < NB_ST; k++) r[8*k +: 8] = ref_sbox(d[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [31:0] model_kw(input logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < NB_KW; k++) r[8*k +: 8] = ref_sbox(d[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Driver tasks: raise valid, hold until accepted, then scramble the input.
    task automatic send_st(input int w, input logic [127:0] d, input logic [127:0] e, output int acc);
        int n;
        @(negedge clk);
        st_valid[w] = 1'b1;
        st_in[w]    = d;
        #1;
        n = 0;
        while (!st_ready[w] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!st_ready[w]) begin
            check("st_accept_timeout", 128'(st_ready[w]), 128'(1));
            st_valid[w] = 1'b0;
            acc = -1;
        end else begin
            acc = cyc;
            st_exp_q.push_back(e);
            st_cyc_q.push_back(cyc + NB_ST + 1);
            @(posedge clk);
            #1;
            st_valid[w] = 1'b0;
            st_in[w]    = rand128();
        end
    endtask

    task automatic send_kw(input int w, input logic [31:0] d, input logic [31:0] e, output int acc);
        int n;
        @(negedge clk);
        kw_valid[w] = 1'b1;
        kw_in[w]    = d;
        #1;
        n = 0;
        while (!kw_ready[w] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!kw_ready[w]) begin
            check("kw_accept_timeout", 128'(kw_ready[w]), 128'(1));
            kw_valid[w] = 1'b0;
            acc = -1;
        end else begin
            acc = cyc;
            kw_exp_q.push_back(e);
            kw_cyc_q.push_back(cyc + NB_KW + 1);
            @(posedge clk);
            #1;
            kw_valid[w] = 1'b0;
            kw_in[w]    = $urandom();
        end
    endtask

    // Wait for outstanding results, then confirm the outputs hold their last value.
    task automatic drain(input int w);
        int n;
        n = 0;
        while ((st_exp_q.size() != 0 || kw_exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain_pending", 128'(st_exp_q.size() + kw_exp_q.size()), 128'(0));
        st_exp_q.delete(); st_cyc_q.delete(); kw_exp_q.delete(); kw_cyc_q.delete();
        repeat (2) @(negedge clk);
        #2;
        check("st_out_hold", st_out[w], last_st[w]);
        check("kw_out_hold", 128'(kw_out[w]), 128'(last_kw[w]));
        check("idle_after_done", 128'(busy[w]), 128'(0));
    endtask

    // Scoreboard: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            for (int w = 0; w < 2; w++) begin
                if (st_done[w]) begin
                    if (st_exp_q.size() == 0) begin
                        check("st_done_spurious", 128'(st_done[w]), 128'(0));
                    end else begin
                        last_st[w] = st_exp_q.pop_front();
                        check("st_out", st_out[w], last_st[w]);
                        check("st_done_cycle", 128'(cyc), 128'(st_cyc_q.pop_front()));
                        check("busy_in_done", 128'(busy[w]), 128'(1));
                    end
                end
                if (kw_done[w]) begin
                    if (kw_exp_q.size() == 0) begin
                        check("kw_done_spurious", 128'(kw_done[w]), 128'(0));
                    end else begin
                        last_kw[w] = kw_exp_q.pop_front();
                        check("kw_out", 128'(kw_out[w]), 128'(last_kw[w]));
                        check("kw_done_cycle", 128'(cyc), 128'(kw_cyc_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int acc_a;
        int acc_b;
        logic [127:0] sd;
        logic [31:0]  kd;

        vecs[0] = '{1'b0, 128'h0, {16{8'h63}}};
        vecs[1] = '{1'b1, 128'hcf4f3c09, 128'h8a84eb01};
        vecs[2] = '{1'b0, 128'h0153, {{14{8'h63}}, 8'h7c, 8'hed}};
        vecs[3] = '{1'b1, 128'h0, 128'h63636363};
        for (int i = 4; i < 8; i++) begin
            vecs[i].is_kw = (i % 2 == 1);
            vecs[i].din   = vecs[i].is_kw ? 128'($urandom()) : rand128();
            vecs[i].exp   = vecs[i].is_kw ? 128'(model_kw(vecs[i].din[31:0])) : model_st(vecs[i].din);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_dbg_state", 128'(dbg_state[0]), 128'(0));
        check("rst_busy", 128'(busy[0]), 128'(0));
        check("rst_st_out", st_out[0], 128'(0));
        check("rst_kw_out", 128'(kw_out[0]), 128'(0));
        check("rst_done", 128'({st_done[0], kw_done[0]}), 128'(0));
        check("rst_readies", 128'({st_ready[0], kw_ready[0]}), 128'(2'b11));

        // Table-driven vectors through the priority-1 instance.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_kw) send_kw(0, vecs[i].din[31:0], vecs[i].exp[31:0], acc_a);
            else               send_st(0, vecs[i].din, vecs[i].exp, acc_a);
            drain(0);
        end

        // Back-to-back throughput.
        sd = rand128();
        send_st(0, sd, model_st(sd), acc_a);
        sd = rand128();
        send_st(0, sd, model_st(sd), acc_b);
        check("st_throughput", 128'(acc_b - acc_a), 128'(NB_ST + 2));
        drain(0);
        kd = $urandom();
        send_kw(0, kd, model_kw(kd), acc_a);
        kd = $urandom();
        send_kw(0, kd, model_kw(kd), acc_b);
        check("kw_throughput", 128'(acc_b - acc_a), 128'(NB_KW + 2));
        drain(0);

        // Simultaneous requests, key-word priority.
        for (int w = 0; w < 2; w++) begin
            sd = rand128();
            kd = $urandom();
            fork
                send_kw(w, kd, model_kw(kd), acc_a);
                send_st(w, sd, model_st(sd), acc_b);
            join
            if (w == 0) check("prio_kw_first", 128'(acc_b - acc_a), 128'(NB_KW + 2));
            else        check("prio_st_first", 128'(acc_a - acc_b), 128'(NB_ST + 2));
            drain(w);
        end

        // Reset in the middle of a state run: no done, outputs cleared.
        sd = rand128();
        send_st(0, sd, model_st(sd), acc_a);
        while (cyc < acc_a + 8) @(negedge clk);
        rst = 1'b1;
        void'(st_exp_q.pop_back());
        void'(st_cyc_q.pop_back());
        last_st = '0;
        last_kw = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 128'(busy[0]), 128'(0));
        check("midrst_st_out", st_out[0], 128'(0));
        check("midrst_kw_out", 128'(kw_out[0]), 128'(0));
        check("midrst_state", 128'(dbg_state[0]), 128'(0));
        repeat (25) @(negedge clk);
        send_st(0, vecs[2].din, vecs[2].exp, acc_a);
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
